// File: rtl/pixel_pkg.sv
// Shared types and constants for the pixel writer: request record, FSM states,
// default framebuffer geometry and the linear address helper.
package pixel_pkg;

  localparam int unsigned DEF_FB_W = 640;
  localparam int unsigned DEF_FB_H = 480;
  localparam int unsigned COORD_W  = 11;

  typedef struct packed {
    logic [COORD_W-1:0] x;
    logic [COORD_W-1:0] y;
    logic               color;
  } pixel_req_t;

  typedef enum logic [1:0] {
    S_RUN,
    S_DRAIN,
    S_CLEAR
  } writer_state_t;

  // Full 32-bit y*w + x; callers truncate to their address width.
  function automatic logic [31:0] lin_addr(input logic [COORD_W-1:0] x,
                                           input logic [COORD_W-1:0] y,
                                           input int unsigned w);
    return 32'(y) * w + 32'(x);
  endfunction

endpackage

// File: rtl/pixel_fifo.sv
// Synchronous FIFO of pixel requests with a registered occupancy counter.
// Push while full is accepted only when a pop happens in the same cycle.
module pixel_fifo
  import pixel_pkg::*;
#(
  parameter int unsigned DEPTH = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       push,
  input  pixel_req_t push_data,
  input  logic       pop,
  output pixel_req_t head,
  output logic       full,
  output logic       empty
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  pixel_req_t       mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count_q == '0);
  assign full    = (count_q == CNT_W'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rd_ptr_q];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      if (do_push && !do_pop) begin
        count_q <= count_q + 1'b1;
      end else if (!do_push && do_pop) begin
        count_q <= count_q - 1'b1;
      end
    end
  end

  // Storage needs no reset; occupancy alone defines validity.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_q] <= push_data;
  end

endmodule

// File: rtl/pixel_writer.sv
// Commits (x, y, color) pixel requests to a 1-bpp framebuffer port, clipping
// off-screen requests and offering a whole-screen clear to 0.
module pixel_writer
  import pixel_pkg::*;
#(
  parameter int unsigned FB_W       = DEF_FB_W,
  parameter int unsigned FB_H       = DEF_FB_H,
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned ADDR_W     = 19
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [10:0]       in_x,
  input  logic [10:0]       in_y,
  input  logic              in_color,
  input  logic              clear_req,
  output logic              clear_busy,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_data,
  input  logic              mem_ready,
  output logic [15:0]       drop_count
);

  localparam int unsigned       FB_PIXELS = FB_W * FB_H;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FB_PIXELS - 1);

  writer_state_t     state_q, state_d;
  logic [ADDR_W-1:0] clr_cnt_q, clr_cnt_d;
  logic              out_valid_q;
  logic [ADDR_W-1:0] out_addr_q;
  logic              out_data_q;
  logic [15:0]       drop_q;

  pixel_req_t fifo_wdata;
  pixel_req_t fifo_head;
  logic       fifo_full;
  logic       fifo_empty;
  logic       fifo_push;
  logic       fifo_pop;
  logic       xfer;
  logic       on_screen;

  // Gated by reset so nothing is offered while reset is held.
  assign in_ready  = reset && (state_q == S_RUN) && !fifo_full;
  assign xfer      = in_valid && in_ready;
  assign on_screen = (32'(in_x) < FB_W) && (32'(in_y) < FB_H);
  assign fifo_push = xfer && on_screen;
  assign fifo_pop  = !fifo_empty && (!out_valid_q || mem_ready);

  assign fifo_wdata = '{x: in_x, y: in_y, color: in_color};

  pixel_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .push     (fifo_push),
    .push_data(fifo_wdata),
    .pop      (fifo_pop),
    .head     (fifo_head),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_valid_q <= 1'b0;
      out_addr_q  <= '0;
      out_data_q  <= 1'b0;
    end else if (fifo_pop) begin
      out_valid_q <= 1'b1;
      out_addr_q  <= ADDR_W'(lin_addr(fifo_head.x, fifo_head.y, FB_W));
      out_data_q  <= fifo_head.color;
    end else if (mem_ready) begin
      out_valid_q <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      drop_q <= '0;
    end else if (xfer && !on_screen && drop_q != 16'hFFFF) begin
      drop_q <= drop_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_RUN;
      clr_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    unique case (state_q)
      S_RUN: begin
        if (clear_req) state_d = S_DRAIN;
      end
      S_DRAIN: begin
        if (fifo_empty && !out_valid_q) begin
          state_d   = S_CLEAR;
          clr_cnt_d = '0;
        end
      end
      S_CLEAR: begin
        if (mem_ready) begin
          if (clr_cnt_q == LAST_ADDR) state_d = S_RUN;
          else                        clr_cnt_d = clr_cnt_q + 1'b1;
        end
      end
      default: state_d = S_RUN;
    endcase
  end

  // The clear sweep owns the memory port; the pixel path is idle by then.
  always_comb begin
    mem_we   = out_valid_q;
    mem_addr = out_addr_q;
    mem_data = out_data_q;
    if (state_q == S_CLEAR) begin
      mem_we   = 1'b1;
      mem_addr = clr_cnt_q;
      mem_data = 1'b0;
    end
  end

  assign clear_busy = (state_q != S_RUN);
  assign drop_count = drop_q;

endmodule

// File: tb/tb_pixel_writer.sv
// Self-checking bench for pixel_writer: a queue-based model of accepted writes
// and clip counts is compared against a monitor of the memory port.
module tb_pixel_writer;

  // Reduced height keeps each clear pass short; width stays at 640.
  localparam int unsigned FB_W       = 640;
  localparam int unsigned FB_H       = 48;
  localparam int unsigned FIFO_DEPTH = 8;
  localparam int unsigned ADDR_W     = 19;
  localparam int unsigned FB_PIXELS  = FB_W * FB_H;

  logic              clk       = 1'b0;
  logic              reset     = 1'b0;
  logic              in_valid  = 1'b0;
  logic [10:0]       in_x      = '0;
  logic [10:0]       in_y      = '0;
  logic              in_color  = 1'b0;
  logic              clear_req = 1'b0;
  logic              mem_ready = 1'b1;
  logic              in_ready;
  logic              clear_busy;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_data;
  logic [15:0]       drop_count;

  int errors = 0;
  int checks = 0;
  int exp_drop = 0;
  logic [ADDR_W:0] exp_q[$];
  logic [ADDR_W:0] got_q[$];

  always #5 clk = ~clk;

  pixel_writer #(
    .FB_W      (FB_W),
    .FB_H      (FB_H),
    .FIFO_DEPTH(FIFO_DEPTH),
    .ADDR_W    (ADDR_W)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_x      (in_x),
    .in_y      (in_y),
    .in_color  (in_color),
    .clear_req (clear_req),
    .clear_busy(clear_busy),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_data  (mem_data),
    .mem_ready (mem_ready),
    .drop_count(drop_count)
  );

  // Writes visible mid-cycle are the ones accepted at the next posedge.
  always @(negedge clk) begin
    if (reset && mem_we && mem_ready) got_q.push_back({mem_addr, mem_data});
  end

  task automatic model_accept(input logic [10:0] x, input logic [10:0] y, input logic c);
    int unsigned a;
    if (x < FB_W && y < FB_H) begin
      a = FB_W * y + x;
      exp_q.push_back({a[ADDR_W-1:0], c});
    end else if (exp_drop < 65535) begin
      exp_drop++;
    end
  endtask

  // Starts and ends at posedge+1; the request transfers at the edge in between.
  task automatic offer(input logic v, input logic [10:0] x, input logic [10:0] y,
                       input logic c, output bit took);
    in_valid = v;
    in_x     = x;
    in_y     = y;
    in_color = c;
    @(negedge clk);
    took = v && in_ready;
    if (took) model_accept(x, y, c);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_writes(input int budget, output bit ok);
    int n = 0;
    while (got_q.size() < exp_q.size() && n < budget) begin
      idle(1);
      n++;
    end
    idle(4);
    ok = (got_q.size() >= exp_q.size());
  endtask

  function automatic int count_bad();
    int bad = 0;
    logic [ADDR_W:0] g, e;
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      g = got_q[i];
      e = exp_q[i];
      if (g !== e) begin
        if (bad == 0)
          $display("  first diff at %0d: got addr %0d data %0b, want addr %0d data %0b",
                   i, g[ADDR_W:1], g[0], e[ADDR_W:1], e[0]);
        bad++;
      end
    end
    return bad;
  endfunction

  task automatic flush();
    got_q.delete();
    exp_q.delete();
  endtask

  task automatic test_reset();
    #2;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL rst_in_ready: got %b want 0", in_ready); end
    checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL rst_mem_we: got %b want 0", mem_we); end
    checks++; if (mem_addr !== '0 || mem_data !== 1'b0) begin errors++; $display("FAIL rst_mem_bus: got addr %0d data %b want 0 0", mem_addr, mem_data); end
    checks++; if (drop_count !== 16'd0 || clear_busy !== 1'b0) begin errors++; $display("FAIL rst_status: got drop %0d busy %b want 0 0", drop_count, clear_busy); end
    @(negedge clk);
    reset = 1'b1;
    idle(1);
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_release_ready: got %b want 1", in_ready); end
  endtask

  task automatic test_single(input string tag);
    bit took;
    flush();
    mem_ready = 1'b1;
    offer(1'b1, 11'd3, 11'd2, 1'b1, took);
    checks++; if (took !== 1'b1 || mem_we !== 1'b0) begin errors++; $display("FAIL %s_push: got took %b mem_we %b want 1 0", tag, took, mem_we); end
    idle(1);
    checks++; if (mem_we !== 1'b1 || mem_addr !== ADDR_W'(1283) || mem_data !== 1'b1) begin errors++; $display("FAIL %s_write: got we %b addr %0d data %b want 1 1283 1", tag, mem_we, mem_addr, mem_data); end
    idle(1);
    checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL %s_one_cycle: got mem_we %b want 0", tag, mem_we); end
    flush();
  endtask

  task automatic test_clip();
    bit t0, t1, t2, ok;
    logic [ADDR_W:0] g;
    flush();
    offer(1'b1, 11'd640, 11'd0, 1'b1, t0);
    offer(1'b1, 11'd5, 11'(FB_H), 1'b1, t1);
    idle(4);
    checks++; if (t0 !== 1'b1 || t1 !== 1'b1 || in_ready !== 1'b1) begin errors++; $display("FAIL clip_ready: got took %b%b ready %b want 11 1", t0, t1, in_ready); end
    checks++; if (got_q.size() != 0) begin errors++; $display("FAIL clip_no_write: got %0d writes want 0", got_q.size()); end
    checks++; if (drop_count !== 16'd2) begin errors++; $display("FAIL clip_drop: got %0d want 2", drop_count); end
    offer(1'b1, 11'(FB_W - 1), 11'(FB_H - 1), 1'b1, t2);
    wait_writes(50, ok);
    g = (got_q.size() > 0) ? got_q[0] : '0;
    checks++; if (!ok || g !== {ADDR_W'(FB_PIXELS - 1), 1'b1}) begin errors++; $display("FAIL clip_corner: got addr %0d data %b want %0d 1", g[ADDR_W:1], g[0], FB_PIXELS - 1); end
    flush();
  endtask

  task automatic test_backpressure();
    bit took, ok;
    int acc = 0;
    int bad;
    flush();
    mem_ready = 1'b0;
    for (int cyc = 0; cyc < 12; cyc++) begin
      offer(1'b1, 11'(acc + 10), 11'(acc), acc[0], took);
      if (took) acc++;
    end
    checks++; if (acc != 9 || in_ready !== 1'b0) begin errors++; $display("FAIL bp_accepted: got %0d ready %b want 9 0", acc, in_ready); end
    idle(3);
    checks++; if (mem_we !== 1'b1 || mem_addr !== ADDR_W'(10) || mem_data !== 1'b0) begin errors++; $display("FAIL bp_hold: got we %b addr %0d data %b want 1 10 0", mem_we, mem_addr, mem_data); end
    checks++; if (got_q.size() != 0) begin errors++; $display("FAIL bp_stall: got %0d writes want 0", got_q.size()); end
    mem_ready = 1'b1;
    wait_writes(100, ok);
    checks++; if (!ok || got_q.size() != 9 || exp_q.size() != 9) begin errors++; $display("FAIL bp_count: got %0d writes want 9", got_q.size()); end
    bad = count_bad();
    checks++; if (bad != 0) begin errors++; $display("FAIL bp_order: got %0d bad writes want 0", bad); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_ready_back: got %b want 1", in_ready); end
    flush();
  endtask

  task automatic test_random();
    bit took, ok;
    int bad;
    flush();
    for (int i = 0; i < 400; i++) begin
      mem_ready = ($urandom_range(0, 3) != 0);
      offer($urandom_range(0, 9) < 7, 11'($urandom_range(0, FB_W + 20)),
            11'($urandom_range(0, FB_H + 5)), 1'($urandom), took);
    end
    mem_ready = 1'b1;
    wait_writes(200, ok);
    checks++; if (!ok || got_q.size() != exp_q.size()) begin errors++; $display("FAIL rand_count: got %0d writes want %0d", got_q.size(), exp_q.size()); end
    bad = count_bad();
    checks++; if (bad != 0) begin errors++; $display("FAIL rand_order: got %0d bad writes want 0", bad); end
    checks++; if (drop_count !== 16'(exp_drop)) begin errors++; $display("FAIL rand_drop: got %0d want %0d", drop_count, exp_drop); end
    flush();
  endtask

  task automatic test_clear();
    bit t0, t1;
    int n = 0;
    int bad;
    flush();
    mem_ready = 1'b0;
    offer(1'b1, 11'd7, 11'd1, 1'b1, t0);
    clear_req = 1'b1;
    offer(1'b1, 11'd8, 11'd1, 1'b1, t1);
    clear_req = 1'b0;
    checks++; if (t0 !== 1'b1 || t1 !== 1'b1) begin errors++; $display("FAIL clr_same_cycle: got took %b%b want 11", t0, t1); end
    checks++; if (clear_busy !== 1'b1 || in_ready !== 1'b0) begin errors++; $display("FAIL clr_busy: got busy %b ready %b want 1 0", clear_busy, in_ready); end
    for (int a = 0; a < FB_PIXELS; a++) exp_q.push_back({ADDR_W'(a), 1'b0});
    while (clear_busy && n < 3 * FB_PIXELS) begin
      mem_ready = ($urandom_range(0, 7) != 0);
      clear_req = (n == 500);
      idle(1);
      n++;
    end
    clear_req = 1'b0;
    mem_ready = 1'b1;
    checks++; if (clear_busy !== 1'b0) begin errors++; $display("FAIL clr_done: got busy %b after %0d cycles want 0", clear_busy, n); end
    idle(20);
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL clr_ready_back: got %b want 1", in_ready); end
    checks++; if (got_q.size() != FB_PIXELS + 2) begin errors++; $display("FAIL clr_count: got %0d writes want %0d", got_q.size(), FB_PIXELS + 2); end
    bad = count_bad();
    checks++; if (bad != 0) begin errors++; $display("FAIL clr_sequence: got %0d bad writes want 0", bad); end
    flush();
  endtask

  task automatic test_async_reset();
    bit took;
    int n = 0;
    flush();
    mem_ready = 1'b1;
    clear_req = 1'b1;
    offer(1'b0, 11'd0, 11'd0, 1'b0, took);
    clear_req = 1'b0;
    while (!(clear_busy && mem_we && mem_addr == ADDR_W'(1000)) && n < 5000) begin
      @(negedge clk);
      n++;
    end
    checks++; if (!(clear_busy && mem_addr == ADDR_W'(1000))) begin errors++; $display("FAIL ar_reach: got busy %b addr %0d want 1 1000", clear_busy, mem_addr); end
    #2;
    reset = 1'b0;
    #1;
    checks++; if (mem_we !== 1'b0 || clear_busy !== 1'b0) begin errors++; $display("FAIL ar_immediate: got we %b busy %b want 0 0", mem_we, clear_busy); end
    checks++; if (drop_count !== 16'd0 || in_ready !== 1'b0) begin errors++; $display("FAIL ar_status: got drop %0d ready %b want 0 0", drop_count, in_ready); end
    @(negedge clk);
    reset = 1'b1;
    exp_drop = 0;
    idle(1);
    checks++; if (in_ready !== 1'b1 || clear_busy !== 1'b0 || mem_we !== 1'b0) begin errors++; $display("FAIL ar_release: got ready %b busy %b we %b want 1 0 0", in_ready, clear_busy, mem_we); end
    test_single("ar_run");
  endtask

  initial begin
    test_reset();
    test_single("single");
    test_clip();
    test_backpressure();
    test_random();
    test_clear();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation still running at time %0t", $time);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/pixel_writer.md
Name: pixel_writer

Overview:
- Receiving end of the pixel stream produced by the line drawing/animation blocks: accepts (x, y, pixel_color) write requests and commits them to a 1-bit-per-pixel framebuffer memory port.
- Buffers requests in a small FIFO, clips off-screen coordinates and computes linear addresses.
- Provides a whole-screen clear operation, so animators can erase without redrawing.

Parameters:
- FB_W, 640, framebuffer width in pixels.
- FB_H, 480, framebuffer height in pixels.
- FIFO_DEPTH, 8, pixel request FIFO entries (power of two, at least 2).
- ADDR_W, 19, memory address width (must satisfy 2^ADDR_W >= FB_W*FB_H).

Ports:
- clk  in  1  system clock; all logic on posedge.
- reset  in  1  asynchronous, active-low reset (0 = reset asserted).
- in_valid  in  1  pixel request present.
- in_ready  out  1  writer can take a request this cycle.
- in_x  in  11  pixel x coordinate (unsigned).
- in_y  in  11  pixel y coordinate (unsigned).
- in_color  in  1  0 = black, 1 = white.
- clear_req  in  1  single-cycle pulse requesting a full-screen clear to 0.
- clear_busy  out  1  high from the cycle after an accepted clear_req until the clear completes.
- mem_we  out  1  memory write strobe.
- mem_addr  out  ADDR_W  linear address, y*FB_W + x.
- mem_data  out  1  pixel value to write.
- mem_ready  in  1  memory accepts the write when mem_we && mem_ready.
- drop_count  out  16  saturating count of clipped requests.

Behaviour:
- Reset (reset == 0, asynchronous):
  - FIFO is emptied and the output register is invalid.
  - Outputs: mem_we = 0, mem_addr = 0, mem_data = 0, drop_count = 0, clear_busy = 0.
  - FSM goes to S_RUN.
  - in_ready = 0 while reset is asserted.
- Handshake:
  - A request transfers on a posedge with in_valid && in_ready.
  - in_ready = (state == S_RUN) && !fifo_full.
  - Inputs are don't-care when in_valid = 0.
- Clipping:
  - A transferred request with in_x >= FB_W or in_y >= FB_H is consumed but not pushed to the FIFO.
  - drop_count increments by 1 for each such request and saturates at 16'hFFFF.
- Address stage:
  - The FIFO head is popped into the output register when the register is empty, or when it is being accepted this cycle (mem_we && mem_ready).
  - On pop: mem_addr <= y*FB_W + x, computed full-width and truncated to ADDR_W; mem_data <= color; mem_we <= 1.
  - mem_we, mem_addr and mem_data hold stable while mem_we && !mem_ready.
- Latency:
  - With the FIFO empty and mem_ready = 1, a request transferred at edge N is pushed at N, popped at N+1, and mem_we is high in the cycle after edge N+1.
  - Sustained throughput is 1 pixel/cycle.
- Ordering: writes reach memory in request order; there is no reordering or coalescing.
- FSM states:
  - S_RUN: normal operation. clear_req -> S_DRAIN. A request transferring in the same cycle as clear_req is still accepted, and is drawn before the clear.
  - S_DRAIN: in_ready = 0; the FIFO and output register drain normally. When both are empty (and no write is pending), clear counter <= 0 -> S_CLEAR.
  - S_CLEAR: mem_we = 1, mem_data = 0, mem_addr = clear counter. The counter advances on each mem_we && mem_ready. On acceptance of address FB_W*FB_H-1 -> S_RUN.
- clear_busy = (state != S_RUN).
- clear_req is ignored outside S_RUN; requests are not queued.
- Reset asserted mid-clear or mid-drain aborts immediately. Pending pixels are lost and partial writes are not rolled back.
- Width rules:
  - Coordinates are compared unsigned against the parameters.
  - The clear counter is ADDR_W wide.
  - The FIFO occupancy counter is $clog2(FIFO_DEPTH)+1 bits wide.

Decomposition:
- pixel_pkg (shared package):
  - pixel_req_t struct {x[10:0], y[10:0], color}.
  - writer_state_t enum {S_RUN, S_DRAIN, S_CLEAR}.
  - Default FB_W/FB_H constants.
- Sub-module pixel_fifo:
  - Synchronous FIFO of pixel_req_t with push/pop/full/empty.
  - Same clk and active-low async reset.
  - Simultaneous push and pop when full is legal: occupancy is unchanged.
  - A pop when empty is ignored.

Test Plan:
- Single write: reset 0->1; in (x=3, y=2, color=1), mem_ready = 1 -> mem_we one cycle, 2 cycles after transfer, with mem_addr = 1283 and mem_data = 1.
- Clipping: request x=640, y=0, then x=5, y=480 -> no mem_we, drop_count = 2, in_ready stays 1. Then x=639, y=479 -> mem_addr = 307199.
- Backpressure: mem_ready = 0, push 10 pixels -> in_ready falls after 9 accepted (8 in FIFO + 1 in output register). mem_addr/mem_data stay stable. Releasing mem_ready drains all 9 in order.
- Clear: pulse clear_req with 2 pixels pending -> those 2 written first, then exactly 307200 writes of data 0 at addresses 0..307199. clear_busy then drops and in_ready returns to 1.
- Clear ignored: a second clear_req during S_CLEAR -> no extra clear pass, and the total write count is unchanged.
- Async reset mid-clear: assert reset at clear address 1000 between clock edges -> mem_we, clear_busy and drop_count go to 0 immediately, without waiting for a clock edge. After release, in_ready = 1 and state = S_RUN.
